wave_table_loader: RTL and testbench

- Fills the DDS waveform RAM `ram_wave` (16K x 8 simple dual-port) from its write port.
- Either generates a standard waveform (square, triangle, sawtooth) or loads a full table streamed from the host over a valid/ready byte interface.
- Sits directly upstream of `ram_wave`; its `wr_en`/`wr_addr`/`wr_data` drive the RAM write side in the `wr_clk` domain.

---
 rtl/wave_table_loader_pkg.sv | 18 +
 rtl/wave_shape_gen.sv | 31 +++
 rtl/wave_table_loader.sv | 111 +++++++++++
 tb/tb_wave_table_loader.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wave_table_loader_pkg.sv
// Shared mode codes and FSM encoding for the DDS waveform table loader.
package wave_table_loader_pkg;

  typedef enum logic [1:0] {
    MODE_STREAM   = 2'd0,
    MODE_SQUARE   = 2'd1,
    MODE_TRIANGLE = 2'd2,
    MODE_SAWTOOTH = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GEN    = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/wave_shape_gen.sv
// Combinational waveform shaper: maps a table address to its sample for the
// built-in square, triangle and sawtooth shapes.
module wave_shape_gen
  import wave_table_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 8
) (
  input  mode_e                 mode_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [DATA_WIDTH-1:0] sample_o
);

  logic                  upper_half;
  logic [DATA_WIDTH-1:0] ramp;

  assign upper_half = addr_i[ADDR_WIDTH-1];
  // Triangle ramps at twice the sawtooth slope and folds back in the upper half.
  assign ramp       = addr_i[ADDR_WIDTH-2 -: DATA_WIDTH];

  always_comb begin
    sample_o = '0;
    case (mode_i)
      MODE_SQUARE:   sample_o = {DATA_WIDTH{upper_half}};
      MODE_TRIANGLE: sample_o = upper_half ? ~ramp : ramp;
      MODE_SAWTOOTH: sample_o = addr_i[ADDR_WIDTH-1 -: DATA_WIDTH];
      default:       sample_o = '0;
    endcase
  end

endmodule

// File: rtl/wave_table_loader.sv
// Fills the waveform RAM either from a generated shape or from a host byte
// stream; drives the RAM write port with registered strobe/address/data.
module wave_table_loader
  import wave_table_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  wr_clk,
  input  logic                  tb_wr_rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_mode,
  input  logic                  abort,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

  state_e                  state_q;
  mode_e                   mode_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [ADDR_WIDTH-1:0]   addr_d;
  logic                    wr_en_q;
  logic [ADDR_WIDTH-1:0]   wr_addr_q;
  logic [DATA_WIDTH-1:0]   wr_data_q;
  logic                    done_q;
  logic [DATA_WIDTH-1:0]   gen_sample;
  logic                    addr_last;

  wave_shape_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_shape (
    .mode_i   (mode_q),
    .addr_i   (addr_q),
    .sample_o (gen_sample)
  );

  assign addr_d    = addr_q + 1'b1;
  assign addr_last = (addr_q == ADDR_LAST);

  always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
    if (tb_wr_rst) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_STREAM;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            mode_q  <= mode_e'(cmd_mode);
            addr_q  <= '0;
            state_q <= (cmd_mode == MODE_STREAM) ? ST_STREAM : ST_GEN;
          end
        end
        ST_GEN: begin
          if (abort) begin
            state_q <= ST_IDLE;
          end else begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= addr_q;
            wr_data_q <= gen_sample;
            // The counter stops on the last address instead of wrapping.
            if (addr_last) state_q <= ST_DONE;
            else           addr_q  <= addr_d;
          end
        end
        ST_STREAM: begin
          if (abort) begin
            state_q <= ST_IDLE;
          end else if (s_valid) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= addr_q;
            wr_data_q <= s_data;
            if (addr_last) state_q <= ST_DONE;
            else           addr_q  <= addr_d;
          end
        end
        ST_DONE: begin
          // First DONE cycle lets the last write land; the second shows done.
          done_q <= ~done_q;
          if (done_q) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_GEN) || (state_q == ST_STREAM);
  assign s_ready   = (state_q == ST_STREAM) && !abort;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign done      = done_q;

endmodule

// File: tb/tb_wave_table_loader.sv
// Directed bench for wave_table_loader with a behavioural model of the RAM.
module tb_wave_table_loader;

  localparam int AW    = 14;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          wr_clk    = 1'b0;
  logic          tb_wr_rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd_mode  = 2'd0;
  logic          abort     = 1'b0;
  logic          s_valid   = 1'b0;
  logic [DW-1:0] s_data    = '0;
  logic          cmd_ready;
  logic          s_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int hi_writes = 0;
  bit mon_abort = 1'b0;
  logic [DW-1:0] mem [DEPTH];

  always #5 wr_clk = ~wr_clk;

  always @(posedge wr_clk) begin
    cyc <= cyc + 1;
    if (wr_en === 1'b1) begin
      mem[wr_addr] <= wr_data;
      if (mon_abort && wr_addr > 14'd100) hi_writes <= hi_writes + 1;
    end
  end

  wave_table_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .wr_clk    (wr_clk),
    .tb_wr_rst (tb_wr_rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mode  (cmd_mode),
    .abort     (abort),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents a command and returns the index of the edge that accepted it.
  task automatic send_cmd(input logic [1:0] m, output int acc);
    int n;
    n = 0;
    @(negedge wr_clk);
    cmd_valid = 1'b1;
    cmd_mode  = m;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge wr_clk);
      n++;
    end
    @(posedge wr_clk);
    #1 acc = cyc;
    @(negedge wr_clk);
    cmd_valid = 1'b0;
    check("cmd_accept_in_time", 32'(n < 50), 32'd1);
  endtask

  task automatic run_gen(output int first_we, output int done_cyc, output int done_cnt,
                         output int n_we, output int rdy_cyc);
    int n;
    n = 0; first_we = -1; done_cyc = -1; done_cnt = 0; n_we = 0; rdy_cyc = -1;
    while (n < DEPTH + 100) begin
      @(negedge wr_clk);
      n++;
      if (wr_en === 1'b1) begin
        n_we++;
        if (first_we < 0) first_we = cyc;
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (cmd_ready === 1'b1 && done_cnt > 0) begin
        rdy_cyc = cyc;
        break;
      end
    end
    check("gen_finished_in_time", 32'(n < DEPTH + 100), 32'd1);
  endtask

  initial begin
    int acc, first_we, done_cyc, done_cnt, n_we, rdy_cyc;
    int sent, c, gap_viol, early_done, err, n;
    logic [AW-1:0] prev_addr;

    // Reset values while held in reset
    repeat (3) @(negedge wr_clk);
    check("rst_wr_en",   32'(wr_en),   32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_done",    32'(done),    32'd0);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    tb_wr_rst = 1'b0;
    @(negedge wr_clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // TRIANGLE
    send_cmd(2'd2, acc);
    check("tri_busy", 32'(busy), 32'd1);
    run_gen(first_we, done_cyc, done_cnt, n_we, rdy_cyc);
    $display("tri: writes=%0d done_pulses=%0d", n_we, done_cnt);
    check("tri_writes",   32'(n_we),     32'd16384);
    check("tri_done_cnt", 32'(done_cnt), 32'd1);
    check("tri_a0",     32'(mem[0]),     32'h00);
    check("tri_a32",    32'(mem[32]),    32'h01);
    check("tri_a8191",  32'(mem[8191]),  32'hFF);
    check("tri_a8192",  32'(mem[8192]),  32'hFF);
    check("tri_a16383", 32'(mem[16383]), 32'h00);

    // SQUARE with latency
    send_cmd(2'd1, acc);
    run_gen(first_we, done_cyc, done_cnt, n_we, rdy_cyc);
    $display("square: first_we=+%0d done=+%0d ready=+%0d", first_we - acc + 1,
             done_cyc - acc + 1, rdy_cyc - acc + 1);
    check("sq_first_we_lat", 32'(first_we - acc + 1), 32'd2);
    check("sq_done_lat",     32'(done_cyc - acc + 1), 32'd16386);
    check("sq_ready_lat",    32'(rdy_cyc - acc + 1),  32'd16387);
    check("sq_writes",       32'(n_we),      32'd16384);
    check("sq_a8191",        32'(mem[8191]), 32'h00);
    check("sq_a8192",        32'(mem[8192]), 32'hFF);

    // STREAM with a gap every 3rd cycle
    send_cmd(2'd0, acc);
    sent = 0; c = 0; gap_viol = 0; early_done = 0; done_cnt = 0; n = 0;
    prev_addr = wr_addr;
    while (n < 40000) begin
      if (done === 1'b1) begin
        done_cnt++;
        if (sent < DEPTH) early_done++;
      end
      if (wr_en === 1'b0 && wr_addr !== prev_addr) gap_viol++;
      prev_addr = wr_addr;
      if (done_cnt > 0 && cmd_ready === 1'b1) break;
      if (sent < DEPTH) begin
        s_valid = (c % 3 != 2);
        s_data  = 8'hFF - 8'(sent);
      end else begin
        s_valid = 1'b0;
      end
      if (s_valid && s_ready === 1'b1) sent++;
      c++;
      @(negedge wr_clk);
      n++;
    end
    s_valid = 1'b0;
    err = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== 8'hFF - 8'(i)) err++;
    $display("stream: sent=%0d done_pulses=%0d readback_errors=%0d", sent, done_cnt, err);
    check("st_in_time",    32'(n < 40000), 32'd1);
    check("st_sent",       32'(sent),       32'd16384);
    check("st_done_cnt",   32'(done_cnt),   32'd1);
    check("st_early_done", 32'(early_done), 32'd0);
    check("st_addr_hold",  32'(gap_viol),   32'd0);
    check("st_readback",   32'(err),        32'd0);
    check("st_a0",         32'(mem[0]),     32'hFF);
    check("st_a16383",     32'(mem[16383]), 32'h00);
    check("idle_s_ready",  32'(s_ready),    32'd0);

    // Abort during GEN at address 100
    send_cmd(2'd1, acc);
    mon_abort = 1'b1;
    n = 0;
    while (!(wr_en === 1'b1 && wr_addr == 14'd100) && n < 300) begin
      @(negedge wr_clk);
      n++;
    end
    check("ab_reach_100", 32'(n < 300), 32'd1);
    abort = 1'b1;
    @(negedge wr_clk);
    abort = 1'b0;
    check("ab_no_write",  32'(wr_en),     32'd0);
    check("ab_cmd_ready", 32'(cmd_ready), 32'd1);
    check("ab_busy",      32'(busy),      32'd0);
    done_cnt = 0;
    repeat (4) begin
      if (done === 1'b1) done_cnt++;
      @(negedge wr_clk);
    end
    mon_abort = 1'b0;
    $display("abort: writes_above_100=%0d done_pulses=%0d", hi_writes, done_cnt);
    check("ab_hi_writes", 32'(hi_writes), 32'd0);
    check("ab_no_done",   32'(done_cnt),  32'd0);
    check("ab_a100",      32'(mem[100]),  32'h00);
    check("ab_a101",      32'(mem[101]),  32'h9A);

    // SAWTOOTH after abort
    send_cmd(2'd3, acc);
    run_gen(first_we, done_cyc, done_cnt, n_we, rdy_cyc);
    $display("saw: writes=%0d done_pulses=%0d", n_we, done_cnt);
    check("saw_writes",   32'(n_we),        32'd16384);
    check("saw_done_cnt", 32'(done_cnt),    32'd1);
    check("saw_a0",       32'(mem[0]),      32'h00);
    check("saw_a64",      32'(mem[64]),     32'h01);
    check("saw_a101",     32'(mem[101]),    32'h01);
    check("saw_a16383",   32'(mem[16383]),  32'hFF);

    // Reset in the middle of a stream at address 500
    send_cmd(2'd0, acc);
    s_valid = 1'b1;
    s_data  = 8'h5A;
    n = 0;
    while (!(wr_en === 1'b1 && wr_addr == 14'd500) && n < 700) begin
      @(negedge wr_clk);
      n++;
    end
    check("rs_reach_500", 32'(n < 700), 32'd1);
    #1 tb_wr_rst = 1'b1;
    #1;
    check("rs_wr_en",   32'(wr_en),   32'd0);
    check("rs_wr_addr", 32'(wr_addr), 32'd0);
    check("rs_busy",    32'(busy),    32'd0);
    check("rs_s_ready", 32'(s_ready), 32'd0);
    check("rs_done",    32'(done),    32'd0);
    s_valid = 1'b0;
    @(negedge wr_clk);
    tb_wr_rst = 1'b0;
    @(negedge wr_clk);
    check("rs_idle_ready", 32'(cmd_ready), 32'd1);
    check("rs_idle_busy",  32'(busy),      32'd0);
    check("rs_idle_wr_en", 32'(wr_en),     32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
